// File: rtl/inst_envelope.sv
// inst_envelope: per-instrument trigger-loaded intensity with hold and per-frame decay
module inst_envelope #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 2,
  localparam int IW = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          trig_valid,
  input  logic [IW-1:0] trig_inst,
  input  logic [6:0]    trig_velocity,
  output logic [7:0]    inst_intensity [INSTRUMENT_COUNT-1:0],
  output logic          busy,
  output logic          overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] hold [INSTRUMENT_COUNT-1:0];
  logic last, load, overrun_n;
  logic [7:0] cur, decayed;
  logic [8:0] dec;
  assign last = idx == IW'(INSTRUMENT_COUNT - 1);
  assign load = trig_valid && trig_velocity != 7'd0 && int'(trig_inst) < INSTRUMENT_COUNT;
  // one shared decay datapath, fed by the instrument currently under scan
  always_comb begin
    state_n = state == IDLE ? (frame_tick ? SCAN : IDLE) : (last ? IDLE : SCAN);
    idx_n = (state == SCAN && !last) ? idx + 1'b1 : '0;
    overrun_n = overrun || (state == SCAN && frame_tick);
    cur = inst_intensity[idx];
    dec = 9'(cur >> DECAY_SHIFT) + 9'd1;
    decayed = {1'b0, cur} > dec ? cur - dec[7:0] : 8'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      busy <= state_n == SCAN;
      overrun <= overrun_n;
    end
  // a trigger to the instrument being scanned takes priority and skips its decay
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        inst_intensity[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++)
        if (load && trig_inst == IW'(i)) begin
          inst_intensity[i] <= {trig_velocity, trig_velocity[6]};
          hold[i] <= 4'(HOLD_FRAMES);
        end else if (state == SCAN && idx == IW'(i)) begin
          if (hold[i] != 4'd0) hold[i] <= hold[i] - 4'd1;
          else inst_intensity[i] <= decayed;
        end
    end
endmodule

// File: tb/tb_inst_envelope.sv
// tb_inst_envelope: directed stimulus with a cycle-stamped scoreboard for inst_envelope
module tb_inst_envelope;
  localparam int N = 3;
  localparam int BUSY = N;
  localparam int OVR = N + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic trig_valid = 1'b0;
  logic [1:0] trig_inst = '0;
  logic [6:0] trig_velocity = '0;
  logic [7:0] inst_intensity [N-1:0];
  logic busy, overrun;
  int cyc = 0;
  int tests = 0;
  int failed = 0;
  typedef struct {int at; int sel; int val;} exp_t;
  exp_t sb[$];

  inst_envelope #(.INSTRUMENT_COUNT(N), .DECAY_SHIFT(3), .HOLD_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .trig_valid(trig_valid),
    .trig_inst(trig_inst), .trig_velocity(trig_velocity),
    .inst_intensity(inst_intensity), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every expectation due in the current cycle, mid-cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        int act;
        act = sb[i].sel < N ? int'(inst_intensity[sb[i].sel]) :
              sb[i].sel == BUSY ? int'(busy) : int'(overrun);
        tests++;
        if (act != sb[i].val) begin
          failed++;
          $display("FAIL %s%0d cyc=%0d got %0d expected %0d",
                   sb[i].sel < N ? "inst" : sb[i].sel == BUSY ? "busy" : "overrun",
                   sb[i].sel < N ? sb[i].sel : 0, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
  end

  task automatic chk(input int dc, input int sel, input int val);
    sb.push_back('{cyc + dc, sel, val});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trig(input int inst, input int vel);
    trig_valid = 1'b1;
    trig_inst = 2'(inst);
    trig_velocity = 7'(vel);
    step(1);
    trig_valid = 1'b0;
  endtask

  // frame tick sampled at the next edge; channel k settles two cycles later plus k
  task automatic frame(input int ch, input int v, input int ch2 = -1, input int v2 = 0);
    chk(1, BUSY, 1);
    chk(2, BUSY, 1);
    chk(3, BUSY, 1);
    chk(4, BUSY, 0);
    chk(2 + ch, ch, v);
    if (ch2 >= 0) chk(2 + ch2, ch2, v2);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(5);
  endtask

  initial begin
    step(2);
    for (int k = 0; k < N; k++) chk(0, k, 0);
    chk(0, BUSY, 0);
    chk(0, OVR, 0);
    rst_n = 1'b1;
    step(2);
    // velocity mapping and ignored triggers
    chk(1, 1, 8'hFF);
    trig(1, 127);
    chk(1, 1, 8'h81);
    trig(1, 64);
    chk(1, 1, 8'h81);
    trig(1, 0);
    chk(1, 0, 0);
    chk(1, 1, 8'h81);
    chk(1, 2, 0);
    trig(3, 100);
    // hold then decay
    chk(1, 0, 255);
    trig(0, 127);
    step(1);
    frame(0, 255, 1, 129);
    frame(0, 255, 1, 129);
    frame(0, 223, 1, 112);
    frame(0, 195, 1, 97);
    frame(0, 170, 1, 84);
    // decay to zero with saturation
    chk(1, 2, 6);
    trig(2, 3);
    step(1);
    frame(2, 6);
    frame(2, 6);
    frame(2, 5);
    frame(2, 4);
    frame(2, 3);
    frame(2, 2);
    frame(2, 1);
    frame(2, 0);
    frame(2, 0);
    // collision with scan of inst1 plus an overrun tick
    chk(0, OVR, 0);
    chk(1, BUSY, 1);
    chk(3, BUSY, 1);
    chk(3, 1, 255);
    chk(3, OVR, 1);
    chk(4, BUSY, 0);
    chk(5, 1, 255);
    chk(6, BUSY, 0);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    frame_tick = 1'b1;
    trig_valid = 1'b1;
    trig_inst = 2'd1;
    trig_velocity = 7'd127;
    step(1);
    frame_tick = 1'b0;
    trig_valid = 1'b0;
    step(5);
    frame(1, 255);
    frame(1, 255);
    chk(0, OVR, 1);
    frame(1, 223);
    // asynchronous reset in the middle of a scan
    chk(1, 0, 255);
    trig(0, 127);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    chk(0, BUSY, 1);
    step(1);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) chk(0, k, 0);
    chk(0, BUSY, 0);
    chk(0, OVR, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
